// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the memory access stage.
// Holds the FSM state enum, width constants and the request buffer layout.
package memory_access_stage_pkg;

    localparam int XLEN            = 32;
    localparam int REG_W           = 5;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             we;
        logic             regWrite;
        logic             resultSrc;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [XLEN-1:0]  pcPlus4;
    } reqBuf_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter for the memory access stage.
// Ports: clk, rst (async active-low), clear, enable, terminal (last allowed wait cycle).
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // count holds the number of wait cycles already spent; terminal marks
    // the cycle whose increment brings the count up to TIMEOUT.
    assign terminal = enable && (count == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(TIMEOUT))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: data memory handshake, wait/timeout FSM, MEM/WB register.
// Ports: EX/MEM controls and data in, dmem req/ack bus, StallM, MEM/WB outputs.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             ResultSrcM,
    input  logic [REG_W-1:0] RD_M,
    input  logic [XLEN-1:0]  ALU_ResultM,
    input  logic [XLEN-1:0]  WriteDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ack,
    output logic             StallM,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [REG_W-1:0] RD_W,
    output logic [XLEN-1:0]  ALU_ResultW,
    output logic [XLEN-1:0]  ReadDataW,
    output logic [XLEN-1:0]  PCPlus4W,
    output logic             MisalignW,
    output logic             BusErrW
);

    state_t  state;
    state_t  stateNext;
    reqBuf_t rbuf;
    reqBuf_t cur;

    logic access;
    logic misAcc;
    logic idleReq;
    logic waitReq;
    logic startWait;
    logic waitDone;
    logic stallInt;
    logic tc;

    logic             nRegWrite;
    logic             nResultSrc;
    logic [REG_W-1:0] nRd;
    logic [XLEN-1:0]  nAlu;
    logic [XLEN-1:0]  nRdata;
    logic [XLEN-1:0]  nPc4;
    logic             nMis;
    logic             nErr;

    assign access    = MemWriteM | ResultSrcM;
    assign misAcc    = access && (ALU_ResultM[1:0] != 2'b00);
    assign idleReq   = (state == IDLE) && access && !misAcc;
    assign waitReq   = (state == WAIT);
    assign startWait = idleReq && !dmem_ack;
    // An ack in the terminal cycle still completes normally.
    assign waitDone  = waitReq && (dmem_ack || tc);
    assign stallInt  = startWait || (waitReq && !dmem_ack && !tc);

    // Reset gates the combinational outputs so a pending access vanishes at once.
    assign dmem_req = rst && (idleReq || waitReq);
    assign StallM   = rst && stallInt;

    always_comb begin
        cur = '0;
        if (waitReq) begin
            cur = rbuf;
        end else begin
            cur.we        = MemWriteM;
            cur.regWrite  = RegWriteM;
            cur.resultSrc = ResultSrcM;
            cur.rd        = RD_M;
            cur.addr      = ALU_ResultM;
            cur.wdata     = WriteDataM;
            cur.pcPlus4   = PCPlus4M;
        end
    end

    assign dmem_addr  = dmem_req ? cur.addr  : '0;
    assign dmem_wdata = dmem_req ? cur.wdata : '0;
    assign dmem_we    = dmem_req && cur.we;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (startWait) stateNext = WAIT;
            WAIT:    if (waitDone)  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rbuf  <= '0;
        end else begin
            state <= stateNext;
            if (startWait) rbuf <= cur;
        end
    end

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) uTimeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (startWait),
        .enable   (waitReq),
        .terminal (tc)
    );

    always_comb begin
        nRegWrite  = 1'b0;
        nResultSrc = 1'b0;
        nRd        = '0;
        nAlu       = '0;
        nRdata     = '0;
        nPc4       = '0;
        nMis       = 1'b0;
        nErr       = 1'b0;
        unique case (1'b1)
            stallInt: begin
                // bubble: all fields stay zero
            end
            waitDone: begin
                nRegWrite  = dmem_ack && rbuf.regWrite;
                nResultSrc = rbuf.resultSrc;
                nRd        = rbuf.rd;
                nAlu       = rbuf.addr;
                nPc4       = rbuf.pcPlus4;
                nRdata     = (dmem_ack && rbuf.resultSrc) ? dmem_rdata : '0;
                nErr       = !dmem_ack;
            end
            default: begin
                nRegWrite  = RegWriteM && !misAcc;
                nResultSrc = ResultSrcM;
                nRd        = RD_M;
                nAlu       = ALU_ResultM;
                nPc4       = PCPlus4M;
                nRdata     = (idleReq && ResultSrcM) ? dmem_rdata : '0;
                nMis       = misAcc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
            MisalignW   <= 1'b0;
            BusErrW     <= 1'b0;
        end else begin
            RegWriteW   <= nRegWrite;
            ResultSrcW  <= nResultSrc;
            RD_W        <= nRd;
            ALU_ResultW <= nAlu;
            ReadDataW   <= nRdata;
            PCPlus4W    <= nPc4;
            MisalignW   <= nMis;
            BusErrW     <= nErr;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with TIMEOUT=4.
// Single-cycle vectors from a table plus hand sequences for waits, timeout, reset.
module tb_memory_access_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        StallM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        MisalignW;
    logic        BusErrW;

    int nChecks = 0;
    int nFail   = 0;

    memory_access_stage #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .MisalignW   (MisalignW),
        .BusErrW     (BusErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic        ack;
        logic [31:0] rdata;
        logic        eReq;
        logic        eStall;
        logic        eRw;
        logic        eRs;
        logic [4:0]  eRd;
        logic [31:0] eAlu;
        logic [31:0] eRdata;
        logic [31:0] ePc4;
        logic        eMis;
        logic        eErr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic rw, input logic mw, input logic rs,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4,
                         input logic ack, input logic [31:0] rdata);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        ALU_ResultM = alu;
        WriteDataM  = wd;
        PCPlus4M    = pc4;
        dmem_ack    = ack;
        dmem_rdata  = rdata;
    endtask

    // Inputs are applied 1 time unit after a rising edge; comb outputs are
    // sampled 2 units later, registered outputs 1 unit after the next edge.
    task automatic toEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " RegWriteW"}, 32'(RegWriteW), 0);
        chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 0);
        chk({tag, " RD_W"}, 32'(RD_W), 0);
        chk({tag, " ALU_ResultW"}, ALU_ResultW, 0);
        chk({tag, " ReadDataW"}, ReadDataW, 0);
        chk({tag, " PCPlus4W"}, PCPlus4W, 0);
        chk({tag, " MisalignW"}, 32'(MisalignW), 0);
        chk({tag, " BusErrW"}, 32'(BusErrW), 0);
        chk({tag, " dmem_req"}, 32'(dmem_req), 0);
        chk({tag, " StallM"}, 32'(StallM), 0);
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h1004, 0, 32'h0,
                    0, 0, 1, 0, 5'd5, 32'h1234, 32'h0, 32'h1004, 0, 0};
        vecs[1] = '{1, 0, 1, 5'd7, 32'h100, 32'h0, 32'h2004, 1, 32'hDEADBEEF,
                    1, 0, 1, 1, 5'd7, 32'h100, 32'hDEADBEEF, 32'h2004, 0, 0};
        vecs[2] = '{0, 1, 0, 5'd0, 32'h104, 32'h55AA55AA, 32'h2008, 1, 32'h99999999,
                    1, 0, 0, 0, 5'd0, 32'h104, 32'h0, 32'h2008, 0, 0};
        vecs[3] = '{1, 0, 1, 5'd9, 32'h102, 32'h0, 32'h200C, 0, 32'h0,
                    0, 0, 0, 1, 5'd9, 32'h102, 32'h0, 32'h200C, 1, 0};
        vecs[4] = '{0, 1, 0, 5'd3, 32'h203, 32'h1, 32'h2010, 0, 32'h0,
                    0, 0, 0, 0, 5'd3, 32'h203, 32'h0, 32'h2010, 1, 0};
        vecs[5] = '{1, 0, 0, 5'd12, 32'hABCD, 32'h0, 32'h2014, 1, 32'h77777777,
                    0, 0, 1, 0, 5'd12, 32'hABCD, 32'h0, 32'h2014, 0, 0};
        vecs[6] = '{1, 0, 0, 5'd1, 32'h3, 32'h0, 32'h2018, 0, 32'h0,
                    0, 0, 1, 0, 5'd1, 32'h3, 32'h0, 32'h2018, 0, 0};

        rst = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chkAllZero("reset");
        rst = 1'b1;
        toEdge();

        // Single-cycle accesses from IDLE, applied back to back.
        for (int i = 0; i < 7; i++) begin
            setIn(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].alu,
                  vecs[i].wd, vecs[i].pc4, vecs[i].ack, vecs[i].rdata);
            #2;
            chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(vecs[i].eReq));
            chk($sformatf("v%0d StallM", i), 32'(StallM), 32'(vecs[i].eStall));
            if (vecs[i].eReq) begin
                chk($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].alu);
                chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].wd);
                chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vecs[i].mw));
            end
            toEdge();
            chk($sformatf("v%0d RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].eRw));
            chk($sformatf("v%0d ResultSrcW", i), 32'(ResultSrcW), 32'(vecs[i].eRs));
            chk($sformatf("v%0d RD_W", i), 32'(RD_W), 32'(vecs[i].eRd));
            chk($sformatf("v%0d ALU_ResultW", i), ALU_ResultW, vecs[i].eAlu);
            chk($sformatf("v%0d ReadDataW", i), ReadDataW, vecs[i].eRdata);
            chk($sformatf("v%0d PCPlus4W", i), PCPlus4W, vecs[i].ePc4);
            chk($sformatf("v%0d MisalignW", i), 32'(MisalignW), 32'(vecs[i].eMis));
            chk($sformatf("v%0d BusErrW", i), 32'(BusErrW), 32'(vecs[i].eErr));
        end

        // 3-wait store, preceded by an ALU op so the bubble is visible.
        setIn(1, 0, 0, 5'd4, 32'h44, 0, 32'h3000, 0, 0);
        toEdge();
        chk("pre RegWriteW", 32'(RegWriteW), 1);
        for (int c = 0; c < 4; c++) begin
            if (c == 0)
                setIn(0, 1, 0, 5'd0, 32'h200, 32'hA5A5A5A5, 32'h3004, 0, 0);
            else
                setIn(0, 1, 0, 5'd0, 32'hFFFF0000, 32'h0, 32'h0,
                      (c == 3), 32'h12345678);
            #2;
            chk($sformatf("st c%0d dmem_req", c), 32'(dmem_req), 1);
            chk($sformatf("st c%0d dmem_addr", c), dmem_addr, 32'h200);
            chk($sformatf("st c%0d dmem_wdata", c), dmem_wdata, 32'hA5A5A5A5);
            chk($sformatf("st c%0d dmem_we", c), 32'(dmem_we), 1);
            chk($sformatf("st c%0d StallM", c), 32'(StallM), 32'(c != 3));
            toEdge();
            if (c != 3)
                chk($sformatf("st c%0d bubble RegWriteW", c), 32'(RegWriteW), 0);
        end
        chk("st RegWriteW", 32'(RegWriteW), 0);
        chk("st ALU_ResultW", ALU_ResultW, 32'h200);
        chk("st PCPlus4W", PCPlus4W, 32'h3004);
        chk("st ReadDataW", ReadDataW, 0);
        chk("st BusErrW", 32'(BusErrW), 0);

        // Timeout: no ack, 4 WAIT cycles then bus error.
        setIn(1, 0, 1, 5'd6, 32'h40, 0, 32'h4004, 0, 32'hBADBAD00);
        #2;
        chk("to idle StallM", 32'(StallM), 1);
        toEdge();
        for (int w = 1; w <= 4; w++) begin
            #2;
            chk($sformatf("to w%0d dmem_req", w), 32'(dmem_req), 1);
            chk($sformatf("to w%0d StallM", w), 32'(StallM), 32'(w != 4));
            toEdge();
        end
        chk("to BusErrW", 32'(BusErrW), 1);
        chk("to RegWriteW", 32'(RegWriteW), 0);
        chk("to ReadDataW", ReadDataW, 0);
        chk("to ALU_ResultW", ALU_ResultW, 32'h40);
        setIn(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        #2;
        chk("to after dmem_req", 32'(dmem_req), 0);
        toEdge();

        // Ack in the terminal WAIT cycle wins.
        setIn(1, 0, 1, 5'd8, 32'h48, 0, 32'h5004, 0, 0);
        toEdge();
        for (int w = 1; w <= 4; w++) begin
            dmem_ack   = (w == 4);
            dmem_rdata = 32'h11223344;
            #2;
            chk($sformatf("ta w%0d StallM", w), 32'(StallM), 32'(w != 4));
            toEdge();
        end
        chk("ta BusErrW", 32'(BusErrW), 0);
        chk("ta RegWriteW", 32'(RegWriteW), 1);
        chk("ta ReadDataW", ReadDataW, 32'h11223344);
        chk("ta RD_W", 32'(RD_W), 8);

        // Reset in the 2nd WAIT cycle, then a fresh load.
        setIn(1, 0, 1, 5'd10, 32'h80, 0, 32'h6004, 0, 0);
        toEdge();
        toEdge();
        #2;
        chk("rw pre dmem_req", 32'(dmem_req), 1);
        rst = 1'b0;
        #1;
        chkAllZero("rw");
        toEdge();
        chkAllZero("rw held");
        rst = 1'b1;
        setIn(1, 0, 1, 5'd11, 32'h300, 0, 32'h7004, 1, 32'hCAFEF00D);
        #2;
        chk("rl dmem_req", 32'(dmem_req), 1);
        chk("rl dmem_addr", dmem_addr, 32'h300);
        chk("rl StallM", 32'(StallM), 0);
        toEdge();
        chk("rl ReadDataW", ReadDataW, 32'hCAFEF00D);
        chk("rl RegWriteW", 32'(RegWriteW), 1);
        chk("rl RD_W", 32'(RD_W), 11);
        chk("rl BusErrW", 32'(BusErrW), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 255, the maximum cycles to wait for dmem_ack before aborting an access.
REQ-002 The block SHALL have port clk  input  1  clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have inputs RegWriteM, MemWriteM and ResultSrcM, each 1 bit, as EX/MEM controls (ResultSrcM=1 means load).
REQ-005 The block SHALL have input RD_M, 5 bits, the destination register.
REQ-006 The block SHALL have inputs ALU_ResultM, WriteDataM and PCPlus4M, each 32 bits: address/result, store data and link value.
REQ-007 The block SHALL have outputs dmem_req, dmem_we (1 bit each), dmem_addr and dmem_wdata (32 bits each) to the data memory.
REQ-008 The block SHALL have inputs dmem_rdata (32 bits) and dmem_ack (1 bit) from the data memory.
REQ-009 The block SHALL have output StallM, 1 bit; when high, upstream holds the EX/MEM register.
REQ-010 The block SHALL have outputs RegWriteW, ResultSrcW (1 bit each), RD_W (5 bits), and ALU_ResultW, ReadDataW, PCPlus4W (32 bits each), the MEM/WB register.
REQ-011 The block SHALL have outputs MisalignW and BusErrW, 1 bit each, exception flags registered with the instruction.

Function
REQ-012 Access SHALL be defined as MemWriteM | ResultSrcM; non-access instructions pass to MEM/WB in 1 cycle with StallM=0.
REQ-013 FSM states SHALL be IDLE and WAIT.
REQ-014 In IDLE with an aligned access, dmem_req SHALL be 1 combinationally, with dmem_addr=ALU_ResultM, dmem_wdata=WriteDataM and dmem_we=MemWriteM.
REQ-015 In IDLE, dmem_ack=1 in the same cycle SHALL complete the access with zero wait: StallM=0 and MEM/WB loads at the next edge.
REQ-016 In IDLE, an access with no ack SHALL set StallM=1, latch addr/wdata/we/controls/RD/PCPlus4 into a request buffer, and move to WAIT.
REQ-017 In WAIT, dmem_req SHALL stay 1 and addr/wdata/we SHALL be driven from the buffer, held stable until ack.
REQ-018 In WAIT, StallM SHALL be 1 until the ack cycle and 0 in the ack cycle, and the state SHALL return to IDLE at the next edge.
REQ-019 On completion, MEM/WB SHALL load the instruction's controls; ReadDataW=dmem_rdata for loads and 0 for stores.
REQ-020 While StallM=1, MEM/WB SHALL load a bubble: RegWriteW=0, MisalignW=0, BusErrW=0.
REQ-021 When ALU_ResultM[1:0]≠0 on an access, no dmem_req SHALL be issued, StallM SHALL be 0, and MEM/WB SHALL carry MisalignW=1, RegWriteW=0 and the other fields as passed.
REQ-022 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-023 If the wait counter reaches TIMEOUT without ack, the FSM SHALL drop dmem_req, set StallM=0 and complete with BusErrW=1, RegWriteW=0 and ReadDataW=0.
REQ-024 A dmem_ack that arrives in the same cycle as the timeout SHALL win: normal completion, BusErrW=0.
REQ-025 dmem_ack in IDLE without dmem_req SHALL be ignored.
REQ-026 The wait counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL never wrap.
REQ-027 Back-to-back accesses SHALL be supported: an access may start in IDLE in the cycle after a completion.

Reset
REQ-028 On rst=0, state SHALL be IDLE, the counter and buffer SHALL be 0, and all MEM/WB outputs SHALL be 0.
REQ-029 On rst=0, dmem_req SHALL be 0 immediately, including mid-WAIT; the pending access is discarded.
REQ-030 After reset release, the first edge SHALL sample inputs normally.

Structure
REQ-031 A shared package SHALL hold the state enum {IDLE, WAIT}, the TIMEOUT default, and the address/data width constants (32) and register-index width constant (5).
REQ-032 The wait counter SHALL be one sub-module, mem_timeout_counter (clear, enable, terminal-count output).
REQ-033 The MEM/WB register SHALL be implemented in the top module, with no memory inside the block.

Verification
REQ-034 ALU op: RegWriteM=1, RD_M=5, ALU_ResultM=0x1234 -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x1234, StallM never 1.
REQ-035 Zero-wait load: addr 0x100, ack in the same cycle with rdata 0xDEADBEEF -> next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1, StallM=0 throughout.
REQ-036 3-wait store: addr 0x200, wdata 0xA5A5A5A5, ack on the 4th cycle -> dmem_addr/wdata/we stable for 4 cycles, StallM=1 for 3 cycles, bubbles on MEM/WB, then the store completes with RegWriteW=0.
REQ-037 Misaligned load: addr 0x102 -> dmem_req never 1, next cycle MisalignW=1, RegWriteW=0.
REQ-038 Timeout with TIMEOUT=4, no ack -> dmem_req drops after 4 WAIT cycles, BusErrW=1, RegWriteW=0; a second case with ack on the timeout cycle -> BusErrW=0.
REQ-039 Reset asserted in the 2nd WAIT cycle -> dmem_req=0 and all outputs 0 immediately; after release, a new load at 0x300 completes normally.
